// File: rtl/br_issue_sched_if.sv
// ---------------------------------------------------------------------------
// br_issue_sched_if
// Groups the dispatch handshake, the two writeback broadcast buses and the
// registered issue outputs of the branch issue queue.
//   master : dispatch / writeback source and issue consumer (core or bench)
//   slave  : the issue queue itself
// Widths come from the core-wide macros; TAG_W is the ROB tag width.
// ---------------------------------------------------------------------------
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif
`ifndef DATA_WIDTH_BR_OP
`define DATA_WIDTH_BR_OP 4
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface br_issue_sched_if #(
    parameter int TAG_W = $clog2(`ROB_DEPTH)
);
    // dispatch
    logic                         disp_valid;
    logic                         disp_ready;
    logic [`DATA_WIDTH_BR_OP-1:0] disp_op;
    logic [`PC_WIDTH-1:0]         disp_pc;
    logic [`WORD_WIDTH-1:0]       disp_imm;
    logic [TAG_W-1:0]             disp_pdst;
    logic [TAG_W-1:0]             disp_rs1_tag;
    logic [TAG_W-1:0]             disp_rs2_tag;
    logic                         disp_rs1_rdy;
    logic                         disp_rs2_rdy;
    logic [`WORD_WIDTH-1:0]       disp_rs1_val;
    logic [`WORD_WIDTH-1:0]       disp_rs2_val;
    // writeback broadcasts
    logic                         wb0_valid;
    logic [TAG_W-1:0]             wb0_tag;
    logic [`WORD_WIDTH-1:0]       wb0_val;
    logic                         wb1_valid;
    logic [TAG_W-1:0]             wb1_tag;
    logic [`WORD_WIDTH-1:0]       wb1_val;
    // issue stage
    logic                         br_issue_en;
    logic [`DATA_WIDTH_BR_OP-1:0] br_issue_queue_op;
    logic [`PC_WIDTH-1:0]         br_issue_queue_pc;
    logic [`WORD_WIDTH-1:0]       br_issue_queue_imm;
    logic [`WORD_WIDTH-1:0]       br_issue_queue_rs1_value;
    logic [`WORD_WIDTH-1:0]       br_issue_queue_rs2_value;
    logic [TAG_W-1:0]             br_issue_queue_Pdst_out;

    modport master (
        output disp_valid, disp_op, disp_pc, disp_imm, disp_pdst,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_val, disp_rs2_val,
               wb0_valid, wb0_tag, wb0_val, wb1_valid, wb1_tag, wb1_val,
        input  disp_ready, br_issue_en, br_issue_queue_op, br_issue_queue_pc,
               br_issue_queue_imm, br_issue_queue_rs1_value,
               br_issue_queue_rs2_value, br_issue_queue_Pdst_out
    );

    modport slave (
        input  disp_valid, disp_op, disp_pc, disp_imm, disp_pdst,
               disp_rs1_tag, disp_rs2_tag, disp_rs1_rdy, disp_rs2_rdy,
               disp_rs1_val, disp_rs2_val,
               wb0_valid, wb0_tag, wb0_val, wb1_valid, wb1_tag, wb1_val,
        output disp_ready, br_issue_en, br_issue_queue_op, br_issue_queue_pc,
               br_issue_queue_imm, br_issue_queue_rs1_value,
               br_issue_queue_rs2_value, br_issue_queue_Pdst_out
    );
endinterface

// File: rtl/br_issue_sched.sv
// ---------------------------------------------------------------------------
// br_issue_sched
// In-order issue queue for the branch unit. Holds dispatched branch/jump
// uops, captures operand values from two writeback buses and launches the
// oldest entry into fu_br through a registered issue stage once both of its
// operands are ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : squash every entry and any pending issue
//   bus        : dispatch handshake, wb0/wb1 broadcasts, issue outputs
//   iq_count   : number of occupied entries
// IQ_DEPTH must be a power of two and at least 2 (pointers wrap naturally).
// ---------------------------------------------------------------------------
`ifndef ROB_DEPTH
`define ROB_DEPTH 16
`endif
`ifndef DATA_WIDTH_BR_OP
`define DATA_WIDTH_BR_OP 4
`endif
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module br_issue_sched #(
    parameter int IQ_DEPTH = 4,
    parameter int TAG_W    = $clog2(`ROB_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    br_issue_sched_if.slave            bus,
    output logic [$clog2(IQ_DEPTH):0]  iq_count
);
    localparam int PTR_W  = $clog2(IQ_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OP_W   = `DATA_WIDTH_BR_OP;
    localparam int PC_W   = `PC_WIDTH;
    localparam int WORD_W = `WORD_WIDTH;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IQ_DEPTH);

    // entry storage
    logic              vld_q     [IQ_DEPTH];
    logic [OP_W-1:0]   op_q      [IQ_DEPTH];
    logic [PC_W-1:0]   pc_q      [IQ_DEPTH];
    logic [WORD_W-1:0] imm_q     [IQ_DEPTH];
    logic [TAG_W-1:0]  pdst_q    [IQ_DEPTH];
    logic [TAG_W-1:0]  rs1_tag_q [IQ_DEPTH];
    logic [TAG_W-1:0]  rs2_tag_q [IQ_DEPTH];
    logic              rs1_rdy_q [IQ_DEPTH];
    logic              rs2_rdy_q [IQ_DEPTH];
    logic [WORD_W-1:0] rs1_val_q [IQ_DEPTH];
    logic [WORD_W-1:0] rs2_val_q [IQ_DEPTH];

    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;

    // issue stage registers
    logic              iss_en_q;
    logic [OP_W-1:0]   iss_op_q;
    logic [PC_W-1:0]   iss_pc_q;
    logic [WORD_W-1:0] iss_imm_q;
    logic [WORD_W-1:0] iss_rs1_q;
    logic [WORD_W-1:0] iss_rs2_q;
    logic [TAG_W-1:0]  iss_pdst_q;

    logic              wb0_valid, wb1_valid;
    logic [TAG_W-1:0]  wb0_tag, wb1_tag;
    logic [WORD_W-1:0] wb0_val, wb1_val;

    logic full, empty, disp_fire, can_issue;

    assign wb0_valid = bus.wb0_valid;
    assign wb0_tag   = bus.wb0_tag;
    assign wb0_val   = bus.wb0_val;
    assign wb1_valid = bus.wb1_valid;
    assign wb1_tag   = bus.wb1_tag;
    assign wb1_val   = bus.wb1_val;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    // Readiness comes from registered state only, so a wakeup this cycle
    // lets the head go no earlier than next cycle. A full queue stays
    // closed even when the head pops in the same cycle.
    assign disp_fire = bus.disp_valid && !full && !flush;
    assign can_issue = !empty && rs1_rdy_q[head_q] && rs2_rdy_q[head_q] && !flush;

    // Returns {rdy, value}: an already-ready operand keeps its value;
    // otherwise a tag match on wb0 wins over wb1.
    function automatic logic [WORD_W:0] capture(input logic              rdy,
                                                input logic [WORD_W-1:0] val,
                                                input logic [TAG_W-1:0]  tag);
        if (rdy)                           return {1'b1, val};
        if (wb0_valid && (wb0_tag == tag)) return {1'b1, wb0_val};
        if (wb1_valid && (wb1_tag == tag)) return {1'b1, wb1_val};
        return {1'b0, val};
    endfunction

    // Entry payload and operand wakeup; validity is tracked separately, so
    // this storage needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (vld_q[i]) begin
                {rs1_rdy_q[i], rs1_val_q[i]} <= capture(rs1_rdy_q[i], rs1_val_q[i], rs1_tag_q[i]);
                {rs2_rdy_q[i], rs2_val_q[i]} <= capture(rs2_rdy_q[i], rs2_val_q[i], rs2_tag_q[i]);
            end
        end
        // the tail slot is never valid while dispatch is open, so this
        // write cannot collide with the wakeup above
        if (disp_fire) begin
            op_q[tail_q]      <= bus.disp_op;
            pc_q[tail_q]      <= bus.disp_pc;
            imm_q[tail_q]     <= bus.disp_imm;
            pdst_q[tail_q]    <= bus.disp_pdst;
            rs1_tag_q[tail_q] <= bus.disp_rs1_tag;
            rs2_tag_q[tail_q] <= bus.disp_rs2_tag;
            {rs1_rdy_q[tail_q], rs1_val_q[tail_q]} <=
                capture(bus.disp_rs1_rdy, bus.disp_rs1_val, bus.disp_rs1_tag);
            {rs2_rdy_q[tail_q], rs2_val_q[tail_q]} <=
                capture(bus.disp_rs2_rdy, bus.disp_rs2_val, bus.disp_rs2_tag);
        end
    end

    // Pointers, occupancy and the registered issue stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) vld_q[i] <= 1'b0;
            iss_en_q   <= 1'b0;
            iss_op_q   <= '0;
            iss_pc_q   <= '0;
            iss_imm_q  <= '0;
            iss_rs1_q  <= '0;
            iss_rs2_q  <= '0;
            iss_pdst_q <= '0;
        end else if (flush) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) vld_q[i] <= 1'b0;
            iss_en_q <= 1'b0;
        end else begin
            iss_en_q <= can_issue;
            if (disp_fire) begin
                vld_q[tail_q] <= 1'b1;
                tail_q        <= tail_q + PTR_ONE;
            end
            // issue fields hold their last values when nothing launches
            if (can_issue) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= head_q + PTR_ONE;
                iss_op_q      <= op_q[head_q];
                iss_pc_q      <= pc_q[head_q];
                iss_imm_q     <= imm_q[head_q];
                iss_rs1_q     <= rs1_val_q[head_q];
                iss_rs2_q     <= rs2_val_q[head_q];
                iss_pdst_q    <= pdst_q[head_q];
            end
            case ({disp_fire, can_issue})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.disp_ready               = !full;
    assign bus.br_issue_en              = iss_en_q;
    assign bus.br_issue_queue_op        = iss_op_q;
    assign bus.br_issue_queue_pc        = iss_pc_q;
    assign bus.br_issue_queue_imm       = iss_imm_q;
    assign bus.br_issue_queue_rs1_value = iss_rs1_q;
    assign bus.br_issue_queue_rs2_value = iss_rs2_q;
    assign bus.br_issue_queue_Pdst_out  = iss_pdst_q;
    assign iq_count                     = count_q;

endmodule
